// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: store_size and funct3
// encodings, the access FSM states and the access-size byte mask.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_LOAD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        DONE,
        ERR
    } state_e;

    // Byte mask of an access of the given size, LSB-justified
    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load data extraction.
// Ports: data (64b {hi,lo} bus words), off (byte offset), size (access size),
//        is_unsigned (zero- rather than sign-extend), result (32b extended value).
module load_extract
    import mem_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [63:0] shifted;

    always_comb begin
        shifted = data >> {off, 3'b000};
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'd0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: result = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns a decoded load/store request into one or two
// word-wide, byte-enabled bus beats with a req/ack handshake, stalls the core
// until the access completes and returns the extended load data.
// Ports: CLK, RESET (sync, active-high); request mem_en/store_size/funct3/
//        addr/wdata; results rdata/stall/done/misalign_err; bus side
//        bus_req/bus_we/bus_addr/bus_wdata/bus_be out, bus_ack/bus_rdata in.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_en,
    input  logic [1:0]  store_size,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        misalign_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        split_q, split_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;

    // Request decode from the live inputs
    logic        in_store;
    logic [1:0]  in_size;
    logic        in_uns;
    logic [3:0]  in_bytes;
    logic        in_misaligned;

    always_comb begin
        in_store = (store_size != SZ_LOAD);
        in_uns   = (funct3 == F3_LBU) || (funct3 == F3_LHU);
        in_size  = store_size;
        if (!in_store) begin
            case (funct3)
                F3_LB, F3_LBU: in_size = SZ_BYTE;
                F3_LH, F3_LHU: in_size = SZ_HALF;
                F3_LW:         in_size = SZ_WORD;
                default:       in_size = SZ_WORD;
            endcase
        end
        case (in_size)
            SZ_BYTE: in_bytes = 4'd1;
            SZ_HALF: in_bytes = 4'd2;
            default: in_bytes = 4'd4;
        endcase
        in_misaligned = (4'({2'b00, addr[1:0]}) + in_bytes) > 4'd4;
    end

    // Lane placement: live inputs when launching from IDLE, latched fields after
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic [1:0]  src_size;
    logic [1:0]  src_off;
    logic [7:0]  be_full;
    logic [31:0] word0;
    logic [31:0] wd0;
    logic [31:0] wd1;

    always_comb begin
        src_addr  = (state_q == IDLE) ? addr  : addr_q;
        src_wdata = (state_q == IDLE) ? wdata : wdata_q;
        src_size  = (state_q == IDLE) ? in_size : size_q;
        src_off   = src_addr[1:0];
        be_full   = 8'({4'b0000, size_mask(src_size)} << src_off);
        word0     = {src_addr[31:2], 2'b00};
        wd0       = src_wdata << {src_off, 3'b000};
        // Bytes that spilled past the first word; off=0 never splits
        wd1       = src_wdata >> (6'd32 - {1'b0, src_off, 3'b000});
    end

    // Second beat supplies the high word; single beats use the live word as lo
    logic [31:0] ext_hi;
    logic [31:0] ext_lo;
    logic [31:0] ext_result;

    assign ext_hi = (state_q == ACC1) ? bus_rdata : 32'd0;
    assign ext_lo = (state_q == ACC1) ? lo_q : bus_rdata;

    load_extract u_load_extract (
        .data        ({ext_hi, ext_lo}),
        .off         (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_result)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        split_d     = split_q;
        lo_d        = lo_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;

        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = in_size;
                    uns_d   = in_uns;
                    split_d = in_misaligned;
                    if (in_misaligned && !MISALIGN_EN) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ACC0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = in_store;
                        bus_addr_d  = word0;
                        bus_be_d    = be_full[3:0];
                        bus_wdata_d = wd0;
                    end
                end
            end
            ACC0: begin
                if (bus_ack) begin
                    lo_d = bus_rdata;
                    if (split_q) begin
                        state_d     = ACC1;
                        bus_addr_d  = word0 + 32'd4;
                        bus_be_d    = be_full[7:4];
                        bus_wdata_d = wd1;
                    end else begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        bus_req_d = 1'b0;
                        if (!bus_we_q) rdata_d = ext_result;
                    end
                end
            end
            ACC1: begin
                if (bus_ack) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) rdata_d = ext_result;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            split_q     <= 1'b0;
            lo_q        <= 32'd0;
            rdata_q     <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            split_q     <= split_d;
            lo_q        <= lo_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
        end
    end

    assign stall        = mem_en && (state_q != DONE) && (state_q != ERR);
    assign rdata        = rdata_q;
    assign done         = done_q;
    assign misalign_err = err_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_be       = bus_be_q;

endmodule
